fc_dma_loader: RTL and testbench
================================

Name: fc_dma_loader

Overview:
- Parametrised sequential DMA loader for the fully-connected stage.
- Fetches a layer's operands from word-addressed RAM over a single-outstanding read handshake: input vector X (optional), weight matrix W, then bias vector B.
- Streams each word, tagged with destination region and row/column index, into the FC operand buffers.
- Supports multi-layer operation: load_x=0 reuses the X already held (e.g. layer 2 consuming layer 1's output) and fetches only W and B.

Parameters:
WORD_SIZE, 16, data word width
IP_LAYER_SIZE, 128, input neurons (X length, W columns)
OP_LAYER_SIZE, 84, output neurons (W rows, B length)
ADDRESS_SIZE, 16, RAM word-address width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begin a fetch (ignored while busy)
load_x  input  1  sampled with start; 1 = fetch X first, 0 = skip X
abort  input  1  terminate current fetch
base_address  input  ADDRESS_SIZE  sampled with start; first word of operand block
busy  output  1  high from cycle after accepted start until cycle after done/abort
done  output  1  one-cycle pulse with final buffer write
ram_rd_en  output  1  one-cycle read request
ram_address  output  ADDRESS_SIZE  read address, valid with ram_rd_en
ram_rd_valid  input  1  read data valid
ram_rd_data  input  WORD_SIZE  read data
buf_wr_en  output  1  buffer write strobe
buf_sel  output  2  0=X, 1=W, 2=B (3 never driven)
buf_row  output  clog2(OP_LAYER_SIZE)  row index (0 for X)
buf_col  output  clog2(IP_LAYER_SIZE)  column index (0 for B)
buf_data  output  WORD_SIZE  registered copy of ram_rd_data

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, ram_rd_en, buf_wr_en = 0; ram_address, buf_sel, buf_row, buf_col, buf_data = 0. Takes effect mid-transfer with no done.
- Memory layout, contiguous from base_address (B): X at B..B+IP-1 if load_x=1; W row-major at WB + r*IP + c, WB = B + (load_x ? IP : 0); B vector at WB + OP*IP + i. Address arithmetic is modulo 2^ADDRESS_SIZE (wraps silently).
- Word order: X[0..IP-1], W[0][0..IP-1] ... W[OP-1][IP-1], B[0..OP-1]. Total N = (load_x?IP:0) + OP*IP + OP.
- States:
  - IDLE: start=1 latches base/load_x, goes to REQ. busy=1 from the next cycle.
  - REQ: ram_rd_en=1 for exactly one cycle with the current address, then WAIT.
  - WAIT: hold until ram_rd_valid=1. ram_rd_valid in the REQ cycle or in IDLE is ignored.
  - Valid in WAIT: next cycle buf_wr_en=1 with buf_data, sel, row and col of that word.
  - In that same write cycle, if words remain: ram_rd_en=1 for the next word (REQ behaviour merged, back-to-back).
  - If the word was the last: done=1 in that cycle; IDLE and busy=0 the following cycle.
- Throughput: one word per (L+1) cycles, L≥1 being RAM latency. Only one request is outstanding.
- Counters: col wraps IP-1→0 and increments row in W; region advances X→W→B at end of region.
- abort (any non-IDLE state): next cycle IDLE, busy=0, no done, no further rd_en/wr_en. A late ram_rd_valid is ignored.
- abort and start in the same IDLE cycle: abort wins, start ignored.
- start while busy: ignored. start in the cycle busy falls (IDLE) is accepted.
- Outputs buf_* hold their last value when buf_wr_en=0.

Test Plan:
1. IP=4, OP=3, L=1, base=0x0100, load_x=1, start at cycle 0.
   -> 19 writes; X words from 0x0100–0x0103 (sel 0, col 0–3); W from 0x0104–0x010F (sel 1, rows 0–2); B from 0x0110–0x0112 (sel 2, rows 0–2).
   -> k-th write at cycle 1+2k; done at cycle 39 only; busy=0 at cycle 40.
2. Same with load_x=0.
   -> 15 writes; first write sel=1, row 0 col 0, from 0x0100; last write B[2] from 0x010E; done at cycle 31.
3. Variable latency: ram_rd_valid delayed 1/3/5 cycles randomly; spurious valid in REQ cycle and in IDLE.
   -> data and indices match scoreboard; spurious valids produce no write.
4. base=0xFFFE, load_x=1, IP=4.
   -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 for X; W continues from 0x0002.
5. abort asserted in WAIT during W[1][2].
   -> busy=0 next cycle; no done; late valid ignored; new start then completes normally.
6. reset=0 mid-transfer, then restart; start pulses while busy.
   -> all outputs 0 immediately; restarted run is exact; start while busy causes no second fetch.

Source files
------------

// File: rtl/fc_dma_loader_if.sv
// RAM read port and FC operand-buffer write port of the FC DMA loader.
// No latency of its own; the master issues one read and waits for ram_rd_valid before the next.
interface fc_dma_loader_if #(
    parameter int WORD_SIZE     = 16,
    parameter int IP_LAYER_SIZE = 128,
    parameter int OP_LAYER_SIZE = 84,
    parameter int ADDRESS_SIZE  = 16
);
    localparam int ROW_W = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1;
    localparam int COL_W = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1;

    logic                    ram_rd_en;
    logic [ADDRESS_SIZE-1:0] ram_address;
    logic                    ram_rd_valid;
    logic [WORD_SIZE-1:0]    ram_rd_data;

    logic                    buf_wr_en;
    logic [1:0]              buf_sel;
    logic [ROW_W-1:0]        buf_row;
    logic [COL_W-1:0]        buf_col;
    logic [WORD_SIZE-1:0]    buf_data;

    modport master (
        output ram_rd_en, ram_address,
        input  ram_rd_valid, ram_rd_data,
        output buf_wr_en, buf_sel, buf_row, buf_col, buf_data
    );

    modport slave (
        input  ram_rd_en, ram_address,
        output ram_rd_valid, ram_rd_data,
        input  buf_wr_en, buf_sel, buf_row, buf_col, buf_data
    );
endinterface

// File: rtl/fc_dma_loader.sv
// Sequential X/W/B operand fetch from word-addressed RAM into the FC operand buffers.
// One word per (L+1) cycles: buffer write lands the cycle after ram_rd_valid, next read merges into it.
// Single outstanding read; the loader simply waits in WAIT for as long as the RAM withholds ram_rd_valid.
module fc_dma_loader #(
    parameter int WORD_SIZE     = 16,
    parameter int IP_LAYER_SIZE = 128,
    parameter int OP_LAYER_SIZE = 84,
    parameter int ADDRESS_SIZE  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load_x,
    input  logic                    abort,
    input  logic [ADDRESS_SIZE-1:0] base_address,
    output logic                    busy,
    output logic                    done,
    fc_dma_loader_if.master         bus
);
    localparam int ROW_W = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1;
    localparam int COL_W = (IP_LAYER_SIZE > 1) ? $clog2(IP_LAYER_SIZE) : 1;

    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_W = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t                  state, state_nxt;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [1:0]              cur_sel;
    logic [ROW_W-1:0]        cur_row;
    logic [COL_W-1:0]        cur_col;
    logic                    accept, take, col_end, row_end, last_word;

    assign accept    = (state == IDLE) && start && !abort;
    assign take      = (state == WAIT) && bus.ram_rd_valid && !abort;
    assign col_end   = (cur_col == COL_W'(IP_LAYER_SIZE - 1));
    assign row_end   = (cur_row == ROW_W'(OP_LAYER_SIZE - 1));
    assign last_word = (cur_sel == SEL_B) && row_end;

    assign busy            = (state != IDLE);
    assign done            = (state == FIN);
    assign bus.ram_rd_en   = (state == REQ);
    assign bus.ram_address = addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A REQ entered from WAIT is also the buffer-write cycle of the word just received.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    if (take) state_nxt = last_word ? FIN : REQ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr          <= '0;
            cur_sel       <= SEL_X;
            cur_row       <= '0;
            cur_col       <= '0;
            bus.buf_wr_en <= 1'b0;
            bus.buf_sel   <= 2'd0;
            bus.buf_row   <= '0;
            bus.buf_col   <= '0;
            bus.buf_data  <= '0;
        end else begin
            bus.buf_wr_en <= take;
            if (accept) begin
                addr    <= base_address;
                cur_sel <= load_x ? SEL_X : SEL_W;
                cur_row <= '0;
                cur_col <= '0;
            end else if (take) begin
                // Operand block is contiguous, so the address just steps and wraps.
                addr         <= addr + 1'b1;
                bus.buf_sel  <= cur_sel;
                bus.buf_row  <= cur_row;
                bus.buf_col  <= cur_col;
                bus.buf_data <= bus.ram_rd_data;
                case (cur_sel)
                    SEL_X: begin
                        if (col_end) begin
                            cur_sel <= SEL_W;
                            cur_col <= '0;
                        end else begin
                            cur_col <= cur_col + 1'b1;
                        end
                    end
                    SEL_W: begin
                        if (col_end) begin
                            cur_col <= '0;
                            if (row_end) begin
                                cur_sel <= SEL_B;
                                cur_row <= '0;
                            end else begin
                                cur_row <= cur_row + 1'b1;
                            end
                        end else begin
                            cur_col <= cur_col + 1'b1;
                        end
                    end
                    default: cur_row <= cur_row + 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fc_dma_loader.sv
// Directed bench for fc_dma_loader with a behavioural RAM of programmable latency.
module tb_fc_dma_loader;
    localparam int WS = 16;
    localparam int IP = 4;
    localparam int OP = 3;
    localparam int AS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          load_x = 1'b0;
    logic          abort = 1'b0;
    logic [AS-1:0] base_address = '0;
    logic          busy, done;

    fc_dma_loader_if #(.WORD_SIZE(WS), .IP_LAYER_SIZE(IP), .OP_LAYER_SIZE(OP), .ADDRESS_SIZE(AS)) bus ();

    fc_dma_loader #(.WORD_SIZE(WS), .IP_LAYER_SIZE(IP), .OP_LAYER_SIZE(OP), .ADDRESS_SIZE(AS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_x       (load_x),
        .abort        (abort),
        .base_address (base_address),
        .busy         (busy),
        .done         (done),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM model: data = address ^ 16'h5A3C, valid after lat cycles; spurious valid when nothing is pending.
    int          lat_fixed = 1;
    bit          lat_rand = 1'b0;
    bit          spur = 1'b0;
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [15:0] paddr = '0;

    always @(negedge clk) begin
        if (reset && bus.ram_rd_en) begin
            pending = 1'b1;
            paddr   = bus.ram_address;
            if (lat_rand) begin
                case ($urandom_range(0, 2))
                    0:       cnt = 1;
                    1:       cnt = 3;
                    default: cnt = 5;
                endcase
            end else begin
                cnt = lat_fixed;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.ram_rd_valid = 1'b0;
        bus.ram_rd_data  = '0;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                bus.ram_rd_valid = 1'b1;
                bus.ram_rd_data  = paddr ^ 16'h5A3C;
                pending          = 1'b0;
            end
        end else if (spur) begin
            bus.ram_rd_valid = 1'b1;
            bus.ram_rd_data  = 16'hDEAD;
        end
    end

    // Monitor: buffer writes {sel,row,col,data}, their cycle, read addresses, done pulses.
    logic [21:0] wr_q[$];
    int          wc_q[$];
    logic [15:0] rd_q[$];
    int          done_n = 0;
    int          done_cyc = 0;
    int          done_nowr = 0;
    int          wr0 = 0, rd0 = 0, dn0 = 0;

    always @(negedge clk) begin
        if (bus.ram_rd_en) rd_q.push_back(bus.ram_address);
        if (bus.buf_wr_en) begin
            wr_q.push_back({bus.buf_sel, bus.buf_row, bus.buf_col, bus.buf_data});
            wc_q.push_back(cyc - t0);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc - t0;
            if (!bus.buf_wr_en) done_nowr++;
        end
    end

    // Called at posedge+1; start is sampled on the next edge, which opens relative cycle 1.
    task automatic launch(input logic [15:0] b, input logic lx);
        base_address = b;
        load_x       = lx;
        start        = 1'b1;
        t0           = cyc;
        wr0          = wr_q.size();
        rd0          = rd_q.size();
        dn0          = done_n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (done_n == dn0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_timeout", 32'(n < budget), 1);
        chk("busy_off", 32'(busy), 0);
    endtask

    task automatic verify(input logic [15:0] b, input logic lx, input bit timing);
        int          nx, n, nw, nr, j;
        logic [15:0] a;
        logic [1:0]  es, er, ec;
        logic [21:0] ew;
        nx = lx ? IP : 0;
        n  = nx + OP * IP + OP;
        nw = wr_q.size() - wr0;
        nr = rd_q.size() - rd0;
        chk("n_writes", nw, n);
        chk("n_reads", nr, n);
        chk("n_done", done_n - dn0, 1);
        chk("done_with_write", done_nowr, 0);
        for (int i = 0; i < n && i < nw; i++) begin
            a = b + 16'(i);
            if (i < nx) begin
                es = 2'd0; er = 2'd0; ec = 2'(i);
            end else begin
                j = i - nx;
                if (j < OP * IP) begin
                    es = 2'd1; er = 2'(j / IP); ec = 2'(j % IP);
                end else begin
                    es = 2'd2; er = 2'(j - OP * IP); ec = 2'd0;
                end
            end
            ew = {es, er, ec, a ^ 16'h5A3C};
            chk("write_word", 32'(wr_q[wr0 + i]), 32'(ew));
            if (i < nr) chk("read_addr", 32'(rd_q[rd0 + i]), 32'(a));
            if (timing) chk("write_cycle", wc_q[wr0 + i], 3 + 2 * i);
        end
        if (timing) chk("done_cycle", done_cyc, 1 + 2 * n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, w, r;
        bit          found;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({busy, done, bus.ram_rd_en, bus.buf_wr_en, bus.ram_address, bus.buf_sel}), 0);
        chk("reset_buf", 32'({bus.buf_row, bus.buf_col, bus.buf_data}), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Fixed latency 1 with and without X; the second start lands in the cycle busy falls.
        launch(16'h0100, 1'b1);
        chk("busy_on", 32'(busy), 1);
        chk("rd_en_first", 32'(bus.ram_rd_en), 1);
        wait_idle(200);
        verify(16'h0100, 1'b1, 1'b1);
        launch(16'h0100, 1'b0);
        wait_idle(200);
        verify(16'h0100, 1'b0, 1'b1);

        // Random 1/3/5 latency plus spurious valids in REQ, write and IDLE cycles.
        lat_rand = 1'b1;
        spur     = 1'b1;
        launch(16'h0200, 1'b1);
        wait_idle(800);
        verify(16'h0200, 1'b1, 1'b0);
        w = wr_q.size();
        repeat (6) @(posedge clk);
        #1;
        chk("spurious_idle", wr_q.size() - w, 0);
        spur     = 1'b0;
        lat_rand = 1'b0;

        // Address wrap at the top of the RAM.
        lat_fixed = 2;
        launch(16'hFFFE, 1'b1);
        wait_idle(300);
        verify(16'hFFFE, 1'b1, 1'b0);

        // Abort while waiting for W[1][2] (word 10 at 0x040A).
        lat_fixed = 3;
        launch(16'h0400, 1'b1);
        n = 0;
        found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.ram_rd_en && bus.ram_address == 16'h040A) found = 1'b1;
        end
        chk("abort_req_seen", 32'(found), 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_writes", wr_q.size() - wr0, 10);
        chk("abort_reads", rd_q.size() - rd0, 11);
        chk("abort_no_done", done_n - dn0, 0);

        // Abort and start together in IDLE: abort wins.
        r = rd_q.size();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_start_reads", rd_q.size() - r, 0);

        lat_fixed = 1;
        launch(16'h0400, 1'b1);
        wait_idle(200);
        verify(16'h0400, 1'b1, 1'b1);

        // Start pulses while busy must not disturb the running fetch.
        launch(16'h0500, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        base_address = 16'h0700;
        load_x = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200);
        verify(16'h0500, 1'b0, 1'b1);

        // Asynchronous reset mid-transfer, then an exact restart.
        launch(16'h0600, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ctl", 32'({busy, done, bus.ram_rd_en, bus.buf_wr_en, bus.ram_address, bus.buf_sel}), 0);
        chk("midrst_buf", 32'({bus.buf_row, bus.buf_col, bus.buf_data}), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", done_n - dn0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        launch(16'h0600, 1'b1);
        wait_idle(200);
        verify(16'h0600, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
